// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and op-class helpers
// shared by the HI/LO sequencer and its divider.
package muldiv_pkg;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_MADD  = 4'd2,
    MD_MADDU = 4'd3,
    MD_MSUB  = 4'd4,
    MD_MSUBU = 4'd5,
    MD_DIV   = 4'd6,
    MD_DIVU  = 4'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  function automatic logic is_valid_op(logic [3:0] op);
    return op <= 4'd7;
  endfunction

  function automatic logic is_mul_op(logic [3:0] op);
    return op <= 4'd5;
  endfunction

  function automatic logic is_signed_op(logic [3:0] op);
    logic s;
    case (op)
      MD_MULT, MD_MADD, MD_MSUB, MD_DIV: s = 1'b1;
      default:                           s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_seq_div.sv
// div_radix2: restoring radix-2 divider on unsigned magnitudes.
// Ports: clk/rst, load (capture operands), step (one quotient bit),
// dividend/divisor in, quot/rem out, last (final step this cycle).
module div_radix2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         last
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  dvs;
  logic [CW-1:0] cnt;
  logic [W:0]    sh;
  logic [W:0]    trial;

  // quot starts as the dividend and shifts it out into rem
  // while quotient bits shift in from the bottom.
  assign sh    = {rem, quot[W-1]};
  assign trial = sh - {1'b0, dvs};
  assign last  = step & (cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvs  <= '0;
      cnt  <= '0;
      quot <= '0;
      rem  <= '0;
    end else if (load) begin
      dvs  <= divisor;
      cnt  <= '0;
      quot <= dividend;
      rem  <= '0;
    end else if (step) begin
      cnt  <= cnt + 1'b1;
      quot <= {quot[W-2:0], ~trial[W]};
      rem  <= trial[W] ? sh[W-1:0] : trial[W-1:0];
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: HI/LO op sequencer. Drives the external pipelined
// multiplier (mul_*), runs DIV/DIVU on div_radix2, owns EX stall,
// flush abort and the one-cycle HI/LO write (hilo_we_o, hi_o, lo_o).
// Inputs: clk_i, rst_i, start_i, flush_i, op_i, a_i, b_i, hi_i, lo_i,
// mul_p_i. Outputs: mul_ce/sclr/signed/a/b, stall_o, busy_o, hilo_*.
// Build option MULDIV_DIV_ZERO_FAST_EN: divide by zero skips DIV.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 6,
  parameter int DIV_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [3:0]       op_i,
  input  logic [DIV_W-1:0] a_i,
  input  logic [DIV_W-1:0] b_i,
  input  logic [DIV_W-1:0] hi_i,
  input  logic [DIV_W-1:0] lo_i,
  output logic             mul_ce_o,
  output logic             mul_sclr_o,
  output logic             mul_signed_o,
  output logic [DIV_W-1:0] mul_a_o,
  output logic [DIV_W-1:0] mul_b_o,
  input  logic [2*DIV_W-1:0] mul_p_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             hilo_we_o,
  output logic [DIV_W-1:0] hi_o,
  output logic [DIV_W-1:0] lo_o
);

  localparam int W = DIV_W;

  md_state_t       state;
  md_op_t          op_q;
  logic [W-1:0]    a_q, b_q, hi_q, lo_q;
  logic [2*W-1:0]  res_q, res_nxt;
  logic [3:0]      cnt;
  logic            ce_q, sgn_q, we_q, dz_q;

  logic            accept, in_sgn, dz_in;
  logic [W-1:0]    a_mag_in, b_mag_in;
  logic            a_neg_q, b_neg_q;
  logic [W-1:0]    a_mag_q;
  logic [W-1:0]    div_q, div_r, q_raw, r_raw, q_fix, r_fix;
  logic            div_load, div_en, div_last;

  assign accept = (state == IDLE) & start_i & ~flush_i
                & is_valid_op(op_i);
  assign in_sgn = is_signed_op(op_i);

  assign a_mag_in = (in_sgn & a_i[W-1]) ? -a_i : a_i;
  assign b_mag_in = (in_sgn & b_i[W-1]) ? -b_i : b_i;

`ifdef MULDIV_DIV_ZERO_FAST_EN
  assign dz_in = (b_i == '0);
`else
  assign dz_in = 1'b0;
`endif

  assign div_load = accept & ~is_mul_op(op_i);
  assign div_en   = (state == DIV) & ~flush_i;

  div_radix2 #(.W(W)) u_div (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (div_load),
    .step     (div_en),
    .dividend (a_mag_in),
    .divisor  (b_mag_in),
    .quot     (div_q),
    .rem      (div_r),
    .last     (div_last)
  );

  assign a_neg_q = sgn_q & a_q[W-1];
  assign b_neg_q = sgn_q & b_q[W-1];
  assign a_mag_q = a_neg_q ? -a_q : a_q;

  // fast divide-by-zero never ran the divider: synthesize
  // what the full restoring pass would have produced
  assign q_raw = dz_q ? '1 : div_q;
  assign r_raw = dz_q ? a_mag_q : div_r;
  assign q_fix = (a_neg_q ^ b_neg_q) ? -q_raw : q_raw;
  assign r_fix = a_neg_q ? -r_raw : r_raw;

  // product is only valid in DONE (after MUL_LAT enabled edges),
  // so the mul result is formed there and registered on exit
  always_comb begin
    res_nxt = res_q;
    unique case (op_q)
      MD_MULT, MD_MULTU: res_nxt = mul_p_i;
      MD_MADD, MD_MADDU: res_nxt = {hi_q, lo_q} + mul_p_i;
      MD_MSUB, MD_MSUBU: res_nxt = {hi_q, lo_q} - mul_p_i;
      MD_DIV, MD_DIVU:   res_nxt = {r_fix, q_fix};
      default:           res_nxt = res_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      op_q  <= MD_MULT;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      res_q <= '0;
      cnt   <= '0;
      ce_q  <= 1'b0;
      sgn_q <= 1'b0;
      we_q  <= 1'b0;
      dz_q  <= 1'b0;
    end else if (flush_i) begin
      state <= IDLE;
      cnt   <= '0;
      ce_q  <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= md_op_t'(op_i);
            a_q   <= a_i;
            b_q   <= b_i;
            hi_q  <= hi_i;
            lo_q  <= lo_i;
            sgn_q <= in_sgn;
            dz_q  <= dz_in;
            cnt   <= '0;
            if (is_mul_op(op_i)) begin
              state <= MUL;
              ce_q  <= 1'b1;
            end else if (dz_in) begin
              state <= DONE;
              we_q  <= 1'b1;
            end else begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (cnt == 4'(MUL_LAT - 1)) begin
            state <= DONE;
            ce_q  <= 1'b0;
            we_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (div_last) begin
            state <= DONE;
            we_q  <= 1'b1;
          end
        end
        DONE: begin
          res_q <= res_nxt;
          we_q  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mul_ce_o     = ce_q;
  assign mul_sclr_o   = flush_i;
  assign mul_signed_o = sgn_q;
  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;

  assign stall_o   = accept | (state == MUL) | (state == DIV);
  assign busy_o    = (state != IDLE);
  assign hilo_we_o = we_q & ~flush_i;

  assign hi_o = (state == DONE) ? res_nxt[2*W-1:W] : res_q[2*W-1:W];
  assign lo_o = (state == DONE) ? res_nxt[W-1:0]   : res_q[W-1:0];

endmodule
